// File: rtl/att_row_streamer.sv
// att_row_streamer: captures the full D_W x ROW x COL attention output matrix
//   on a one-cycle I_DATA_VLD pulse and replays it one row per beat over a
//   valid/ready stream.
// Ports: I_CLK, I_ASYN_RSTN (async clear), I_SYNC_RSTN (sync clear);
//   I_DATA_VLD/I_ATT_DATA matrix pulse in; I_RDY/O_VLD/O_ROW_DATA/O_ROW_IDX/O_LAST
//   row stream out; O_BUSY and sticky O_OVF status.
// Optional: ATT_ROW_STREAMER_OVF_CNT_EN adds O_OVF_CNT, a saturating 8-bit count
//   of dropped matrices.
// Row 0 appears the cycle after the pulse; all outputs come from registers,
//   so there is no combinational path from I_RDY to any output.
module att_row_streamer #(
  parameter int D_W = 16,
  parameter int ROW = 16,
  parameter int COL = 16
) (
  input  logic                   I_CLK,
  input  logic                   I_ASYN_RSTN,
  input  logic                   I_SYNC_RSTN,
  input  logic                   I_DATA_VLD,
  input  logic [D_W*ROW*COL-1:0] I_ATT_DATA,
  input  logic                   I_RDY,
  output logic                   O_VLD,
  output logic [D_W*COL-1:0]     O_ROW_DATA,
  output logic [$clog2(ROW)-1:0] O_ROW_IDX,
  output logic                   O_LAST,
  output logic                   O_BUSY,
`ifdef ATT_ROW_STREAMER_OVF_CNT_EN
  output logic [7:0]             O_OVF_CNT,
`endif
  output logic                   O_OVF
);

  localparam int RW = D_W * COL;
  localparam int IW = $clog2(ROW);
  localparam logic [IW-1:0] LAST_IDX = IW'(ROW - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [IW-1:0]          row_cnt_q, row_cnt_d;
  logic [D_W*ROW*COL-1:0] buffer_q;
  logic [RW-1:0]          row_data_q;
  logic                   hs, at_last;
  logic                   capture, advance, drop;

  assign hs      = (state_q == SEND) && I_RDY;
  assign at_last = (row_cnt_q == LAST_IDX);

  // State register
  always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
    if (!I_ASYN_RSTN) begin
      state_q   <= IDLE;
      row_cnt_q <= '0;
    end else if (!I_SYNC_RSTN) begin
      state_q   <= IDLE;
      row_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
    end
  end

  // Next state and datapath strobes
  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    capture   = 1'b0;
    advance   = 1'b0;
    drop      = 1'b0;
    case (state_q)
      IDLE: begin
        if (I_DATA_VLD) begin
          capture   = 1'b1;
          row_cnt_d = '0;
          state_d   = SEND;
        end
      end
      SEND: begin
        if (hs && at_last) begin
          // A pulse coinciding with the final handshake chains straight
          // into the next matrix with no idle beat.
          row_cnt_d = '0;
          if (I_DATA_VLD) begin
            capture = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (hs) begin
            advance   = 1'b1;
            row_cnt_d = row_cnt_q + IW'(1);
          end
          if (I_DATA_VLD) begin
            drop = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Matrix buffer and registered row slice. The row register is loaded with
  // the row the counter will point at next, so it lines up with O_ROW_IDX.
  always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
    if (!I_ASYN_RSTN) begin
      buffer_q   <= '0;
      row_data_q <= '0;
    end else if (!I_SYNC_RSTN) begin
      buffer_q   <= '0;
      row_data_q <= '0;
    end else if (capture) begin
      buffer_q   <= I_ATT_DATA;
      row_data_q <= I_ATT_DATA[(ROW-1)*RW +: RW];
    end else if (advance) begin
      row_data_q <= buffer_q[(ROW-1-int'(row_cnt_d))*RW +: RW];
    end
  end

`ifdef ATT_ROW_STREAMER_OVF_CNT_EN
  logic [7:0] ovf_cnt_q;

  always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
    if (!I_ASYN_RSTN) begin
      ovf_cnt_q <= '0;
    end else if (!I_SYNC_RSTN) begin
      ovf_cnt_q <= '0;
    end else if (drop && (ovf_cnt_q != 8'hFF)) begin
      ovf_cnt_q <= ovf_cnt_q + 8'd1;
    end
  end

  assign O_OVF_CNT = ovf_cnt_q;
  assign O_OVF     = (ovf_cnt_q != 8'd0);
`else
  logic ovf_q;

  always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
    if (!I_ASYN_RSTN) begin
      ovf_q <= 1'b0;
    end else if (!I_SYNC_RSTN) begin
      ovf_q <= 1'b0;
    end else if (drop) begin
      ovf_q <= 1'b1;
    end
  end

  assign O_OVF = ovf_q;
`endif

  assign O_VLD      = (state_q == SEND);
  assign O_BUSY     = (state_q == SEND);
  assign O_LAST     = (state_q == SEND) && at_last;
  assign O_ROW_IDX  = row_cnt_q;
  assign O_ROW_DATA = row_data_q;

endmodule

// File: tb/tb_att_row_streamer.sv
// tb_att_row_streamer: directed bench for att_row_streamer with a matrix-level
//   reference model and a per-cycle compare process, plus literal expectations.
// Ports: drives all DUT inputs, observes all DUT outputs.
module tb_att_row_streamer;
  localparam int D_W = 16;
  localparam int ROW = 16;
  localparam int COL = 16;
  localparam int RW  = D_W * COL;
  localparam int MW  = D_W * ROW * COL;

  logic          I_CLK = 1'b0;
  logic          I_ASYN_RSTN = 1'b0;
  logic          I_SYNC_RSTN = 1'b0;
  logic          I_DATA_VLD = 1'b0;
  logic [MW-1:0] I_ATT_DATA = '0;
  logic          I_RDY = 1'b0;
  logic          O_VLD;
  logic [RW-1:0] O_ROW_DATA;
  logic [3:0]    O_ROW_IDX;
  logic          O_LAST;
  logic          O_BUSY;
  logic          O_OVF;
`ifdef ATT_ROW_STREAMER_OVF_CNT_EN
  logic [7:0]    O_OVF_CNT;
`endif

  int checks = 0;
  int errors = 0;
  int delivered = 0;

  att_row_streamer #(.D_W(D_W), .ROW(ROW), .COL(COL)) dut (
    .I_CLK      (I_CLK),
    .I_ASYN_RSTN(I_ASYN_RSTN),
    .I_SYNC_RSTN(I_SYNC_RSTN),
    .I_DATA_VLD (I_DATA_VLD),
    .I_ATT_DATA (I_ATT_DATA),
    .I_RDY      (I_RDY),
    .O_VLD      (O_VLD),
    .O_ROW_DATA (O_ROW_DATA),
    .O_ROW_IDX  (O_ROW_IDX),
    .O_LAST     (O_LAST),
    .O_BUSY     (O_BUSY),
`ifdef ATT_ROW_STREAMER_OVF_CNT_EN
    .O_OVF_CNT  (O_OVF_CNT),
`endif
    .O_OVF      (O_OVF)
  );

  always #5 I_CLK = ~I_CLK;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (matrix held + row pointer) ----------
  bit [D_W-1:0] m_mat [ROW][COL];
  bit           m_busy = 1'b0;
  int           m_row = 0;
  bit           m_ovf = 1'b0;
  int           m_cnt = 0;
  bit           m_fin, m_acc, m_drp;

  always @(posedge I_CLK or negedge I_ASYN_RSTN) begin
    if (!I_ASYN_RSTN || !I_SYNC_RSTN) begin
      m_busy = 1'b0;
      m_row  = 0;
      m_ovf  = 1'b0;
      m_cnt  = 0;
      for (int r = 0; r < ROW; r++)
        for (int c = 0; c < COL; c++)
          m_mat[r][c] = '0;
    end else begin
      m_fin = m_busy && I_RDY && (m_row == ROW - 1);
      m_acc = I_DATA_VLD && (!m_busy || m_fin);
      m_drp = I_DATA_VLD && m_busy && !m_fin;
      if (m_acc) begin
        for (int r = 0; r < ROW; r++)
          for (int c = 0; c < COL; c++)
            m_mat[r][c] = I_ATT_DATA[((ROW-1-r)*COL + (COL-1-c))*D_W +: D_W];
        m_busy = 1'b1;
        m_row  = 0;
      end else if (m_fin) begin
        m_busy = 1'b0;
        m_row  = 0;
      end else if (m_busy && I_RDY) begin
        m_row++;
      end
      if (m_drp) begin
        m_ovf = 1'b1;
        if (m_cnt < 255) m_cnt++;
      end
    end
  end

  function automatic logic [RW-1:0] exp_row(input int r);
    logic [RW-1:0] v;
    v = '0;
    for (int c = 0; c < COL; c++) v[(COL-1-c)*D_W +: D_W] = m_mat[r][c];
    return v;
  endfunction

  // ---------------- per-cycle compare ------------------------------------
  bit            prev_stall = 1'b0;
  logic [RW-1:0] prev_data;
  logic [3:0]    prev_idx;
  int            exp_idx = 0;

  always @(negedge I_CLK) begin
    if (I_ASYN_RSTN) begin
      chk("vld", O_VLD, m_busy);
      chk("busy", O_BUSY, m_busy);
      chk("ovf", O_OVF, m_ovf);
`ifdef ATT_ROW_STREAMER_OVF_CNT_EN
      chk("ovf_cnt", O_OVF_CNT, m_cnt);
`endif
      if (m_busy) begin
        chk("row_data", O_ROW_DATA, exp_row(m_row));
        chk("row_idx", O_ROW_IDX, m_row);
        chk("last", O_LAST, m_row == ROW - 1);
      end else begin
        chk("last_idle", O_LAST, 1'b0);
      end
      if (prev_stall) begin
        chk("stall_hold_data", O_ROW_DATA, prev_data);
        chk("stall_hold_idx", O_ROW_IDX, prev_idx);
      end
      prev_stall = O_VLD && !I_RDY && I_SYNC_RSTN;
      prev_data  = O_ROW_DATA;
      prev_idx   = O_ROW_IDX;
      if (!I_SYNC_RSTN) begin
        exp_idx = 0;
      end else if (O_VLD && I_RDY) begin
        chk("order_idx", O_ROW_IDX, exp_idx);
        exp_idx = (exp_idx == ROW - 1) ? 0 : exp_idx + 1;
        delivered++;
      end
    end else begin
      prev_stall = 1'b0;
      exp_idx    = 0;
    end
  end

  // ---------------- stimulus helpers -------------------------------------
  task automatic step();
    @(posedge I_CLK);
    #1;
  endtask

  function automatic logic [MW-1:0] make_mat(input bit allmax);
    logic [MW-1:0] m;
    m = '0;
    for (int r = 0; r < ROW; r++)
      for (int c = 0; c < COL; c++)
        m[((ROW-1-r)*COL + (COL-1-c))*D_W +: D_W] = allmax ? 16'h7FFF : D_W'(256*c + r);
    return m;
  endfunction

  task automatic pulse(input logic [MW-1:0] m);
    I_ATT_DATA = m;
    I_DATA_VLD = 1'b1;
    step();
    I_DATA_VLD = 1'b0;
  endtask

  task automatic wait_idx(input int n);
    int k;
    for (k = 0; k < 40; k++) begin
      if (O_VLD && (O_ROW_IDX == 4'(n))) break;
      step();
    end
    checks++;
    if (k == 40) begin
      errors++;
      $display("FAIL wait_idx: row %0d never shown within 40 cycles", n);
    end
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 80; k++) begin
      if (!O_BUSY) break;
      step();
    end
    chk("drain_idle", O_BUSY, 1'b0);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_vld"}, O_VLD, 1'b0);
    chk({nm, "_data"}, O_ROW_DATA, '0);
    chk({nm, "_idx"}, O_ROW_IDX, 4'd0);
    chk({nm, "_last"}, O_LAST, 1'b0);
    chk({nm, "_busy"}, O_BUSY, 1'b0);
    chk({nm, "_ovf"}, O_OVF, 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic [MW-1:0] mat_a, mat_b;

  initial begin
    mat_a = make_mat(1'b0);
    mat_b = make_mat(1'b1);

    // Reset state
    #2;
    chk_all_zero("reset");
    step();
    step();
    I_ASYN_RSTN = 1'b1;
    I_SYNC_RSTN = 1'b1;
    step();

    // 1: single matrix, I_RDY held high
    I_RDY = 1'b1;
    delivered = 0;
    pulse(mat_a);
    chk("t1_r0_vld", O_VLD, 1'b1);
    chk("t1_r0_busy", O_BUSY, 1'b1);
    chk("t1_r0_idx", O_ROW_IDX, 4'd0);
    chk("t1_r0_c3", O_ROW_DATA[(COL-1-3)*D_W +: D_W], 16'h0300);
    repeat (15) step();
    chk("t1_r15_idx", O_ROW_IDX, 4'd15);
    chk("t1_r15_last", O_LAST, 1'b1);
    chk("t1_r15_c15", O_ROW_DATA[D_W-1:0], 16'h0F0F);
    chk("t1_r15_c0", O_ROW_DATA[RW-1 -: D_W], 16'h000F);
    step();
    chk("t1_end_vld", O_VLD, 1'b0);
    chk("t1_end_busy", O_BUSY, 1'b0);
    chk("t1_end_last", O_LAST, 1'b0);
    chk("t1_delivered", delivered, 16);

    // 2: I_RDY pattern 1,0,0,1,0,0,...
    delivered = 0;
    I_RDY = 1'b0;
    pulse(mat_a);
    for (int k = 0; k < 100; k++) begin
      I_RDY = (k % 3 == 0);
      step();
      if (!O_BUSY) break;
    end
    chk("t2_delivered", delivered, 16);
    chk("t2_end_vld", O_VLD, 1'b0);

    // 3: second pulse on the final-row handshake, no gap beat
    I_RDY = 1'b1;
    pulse(mat_a);
    wait_idx(15);
    pulse(mat_b);
    chk("t3_vld", O_VLD, 1'b1);
    chk("t3_idx", O_ROW_IDX, 4'd0);
    chk("t3_c0", O_ROW_DATA[RW-1 -: D_W], 16'h7FFF);
    chk("t3_c15", O_ROW_DATA[D_W-1:0], 16'h7FFF);
    chk("t3_ovf", O_OVF, 1'b0);
    wait_idle();

    // 4: second pulse mid-transfer is dropped
    pulse(mat_a);
    wait_idx(5);
    pulse(mat_b);
    chk("t4_idx", O_ROW_IDX, 4'd6);
    chk("t4_c2", O_ROW_DATA[(COL-1-2)*D_W +: D_W], 16'h0206);
    chk("t4_ovf", O_OVF, 1'b1);
`ifdef ATT_ROW_STREAMER_OVF_CNT_EN
    chk("t4_ovf_cnt", O_OVF_CNT, 8'd1);
`endif
    wait_idle();
    chk("t4_ovf_sticky", O_OVF, 1'b1);

    // 5a: async reset mid-transfer, no clock edge needed
    pulse(mat_a);
    wait_idx(8);
    #1;
    I_ASYN_RSTN = 1'b0;
    #1;
    chk_all_zero("t5_async");
    step();
    step();
    I_ASYN_RSTN = 1'b1;
    repeat (3) step();
    chk("t5_idle_vld", O_VLD, 1'b0);
    chk("t5_idle_busy", O_BUSY, 1'b0);
    pulse(mat_a);
    chk("t5_restart_vld", O_VLD, 1'b1);
    chk("t5_restart_idx", O_ROW_IDX, 4'd0);
    wait_idle();

    // 5b: sync clear mid-transfer acts on the next edge
    pulse(mat_a);
    wait_idx(8);
    I_SYNC_RSTN = 1'b0;
    #2;
    chk("t5_sync_pre_vld", O_VLD, 1'b1);
    step();
    chk_all_zero("t5_sync");
    I_SYNC_RSTN = 1'b1;
    step();
    step();
    chk("t5_sync_idle_vld", O_VLD, 1'b0);

    // 6: 300 drops while stalled
    I_RDY = 1'b0;
    I_ATT_DATA = mat_a;
    I_DATA_VLD = 1'b1;
    repeat (301) step();
    I_DATA_VLD = 1'b0;
    chk("t6_ovf", O_OVF, 1'b1);
`ifdef ATT_ROW_STREAMER_OVF_CNT_EN
    chk("t6_ovf_cnt_sat", O_OVF_CNT, 8'hFF);
`endif
    chk("t6_idx_held", O_ROW_IDX, 4'd0);
    I_RDY = 1'b1;
    wait_idle();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/att_row_streamer.md
Name: att_row_streamer

Overview:
- Reader on the result side of the attention block.
- Captures the full D_W×ROW×COL attention output matrix on each O_DATA_VLD pulse from attention.
- Replays the captured matrix one row per beat over a valid/ready stream toward the output buffer / next MHA stage.
- Decouples the attention block's single-cycle matrix pulse from a back-pressured downstream consumer.

Parameters:
- D_W, 16, element width in bits
- ROW, 16, rows per matrix (sequence length)
- COL, 16, columns per matrix (D_K)

Ports:
- I_CLK  input  1  clock
- I_ASYN_RSTN  input  1  asynchronous active-low reset
- I_SYNC_RSTN  input  1  synchronous active-low clear; same effect as reset, applied on the I_CLK edge
- I_DATA_VLD  input  1  one-cycle pulse; matrix on I_ATT_DATA is valid; driven from attention O_DATA_VLD
- I_ATT_DATA  input  D_W*ROW*COL  packed matrix; driven from attention O_ATT_DATA
- I_RDY  input  1  downstream ready
- O_VLD  output  1  row beat valid
- O_ROW_DATA  output  D_W*COL  current row
- O_ROW_IDX  output  $clog2(ROW)  index of the current row
- O_LAST  output  1  high with the beat for row ROW-1
- O_BUSY  output  1  a matrix is held, or rows remain to be sent
- O_OVF  output  1  sticky flag; a matrix was dropped

Behaviour:
- Packing:
  - Element (r,c) of I_ATT_DATA is at [((ROW-1-r)*COL+(COL-1-c))*D_W +: D_W], so row 0 col 0 sits in the MSBs.
  - Element c of O_ROW_DATA is at [(COL-1-c)*D_W +: D_W].
- Reset (async, or sync clear): state IDLE, row_cnt=0, buffer=0, O_VLD=0, O_ROW_DATA=0, O_ROW_IDX=0, O_LAST=0, O_BUSY=0, O_OVF=0.
- Reset mid-transfer: the remaining rows are abandoned; nothing is emitted after the clear.
- State IDLE:
  - On I_DATA_VLD=1, register the whole I_ATT_DATA into the buffer, set row_cnt=0, go to SEND.
  - Latency: O_VLD=1 with row 0 on the cycle after the pulse.
  - O_BUSY rises in that same cycle.
- State SEND:
  - O_VLD=1. O_ROW_DATA is row row_cnt of the buffer, O_ROW_IDX=row_cnt, O_LAST=(row_cnt==ROW-1).
  - While O_VLD=1 and I_RDY=0, O_ROW_DATA, O_ROW_IDX and O_LAST hold stable.
  - On a handshake (O_VLD & I_RDY) with row_cnt<ROW-1: row_cnt increments and the next row appears the following cycle.
  - Sustained throughput is 1 row per cycle when I_RDY is held at 1.
  - On a handshake with row_cnt==ROW-1 and no I_DATA_VLD in that cycle: go to IDLE; O_VLD, O_LAST and O_BUSY fall the next cycle.
- Simultaneous events:
  - I_DATA_VLD in the same cycle as the final-row handshake: the new matrix is captured and the block stays in SEND with row_cnt=0. Back-to-back matrices have no gap beat.
  - I_DATA_VLD in SEND at any other time: the new matrix is dropped, the buffer is untouched, and O_OVF is set.
  - O_OVF stays set until reset or sync clear.
- I_DATA_VLD held high for several cycles is treated as a separate pulse each cycle; no edge detection is done.
- O_ROW_DATA is a registered slice of the buffer, driven through a row mux from row_cnt. No combinational path from I_RDY to any output.

Optional Feature:
- Macro: ATT_ROW_STREAMER_OVF_CNT_EN.
- Defined:
  - Adds output port O_OVF_CNT, 8 bits wide.
  - Counts dropped matrices and saturates at 8'hFF.
  - Cleared by reset or sync clear.
  - O_OVF equals (O_OVF_CNT != 0).
- Undefined:
  - Port and counter are absent.
  - Only the sticky 1-bit O_OVF exists.

Test Plan:
- Matrix with element (r,c)=16'h0100*c+r, one I_DATA_VLD pulse, I_RDY=1:
  - 16 consecutive beats starting the cycle after the pulse.
  - Beat r has O_ROW_IDX=r and element c = 16'h0100*c+r.
  - O_LAST only on beat 15; O_VLD=0 and O_BUSY=0 on the cycle after beat 15.
- Same matrix, I_RDY toggling 1,0,0,1,…:
  - Row data stable across every stall cycle.
  - All 16 rows delivered exactly once, in order; no duplicates.
- Second pulse (all elements 16'h7FFF) on the row-15 handshake cycle:
  - Next cycle shows row 0 = all 16'h7FFF with O_IDX=0.
  - O_VLD never drops between the two matrices; O_OVF stays 0.
- Second pulse at row 5 under I_RDY=1:
  - Rows 6..15 still come from the first matrix.
  - O_OVF=1 from the next cycle; with ATT_ROW_STREAMER_OVF_CNT_EN, O_OVF_CNT=1.
- I_ASYN_RSTN low at row 8:
  - All outputs 0 immediately, with no clock edge needed.
  - After release, stays IDLE until the next pulse.
  - I_SYNC_RSTN low produces the same result on the next edge.
- With the macro defined, 300 dropped pulses during stalled transfers (I_RDY=0):
  - O_OVF_CNT saturates at 8'hFF.
